id_ex_stage: RTL

- Decode stage plus ID/EX pipeline register of the MIPS datapath; sits directly upstream of execute.
- Drives the register-file read addresses (rs1/rs2) from the IF/ID instruction and consumes the rf read data (Qs1/Qs2).
- Registers operands, immediate and control into EX.
- Contains load-use hazard detection (bubble insertion), flush and downstream back-pressure.

---
 rtl/mips_pkg.sv | 34 +++
 rtl/id_decoder.sv | 33 +++
 rtl/id_ex_stage.sv | 98 +++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// mips_pkg: opcodes, instruction field positions and decode control bundle.
package mips_pkg;

    typedef enum logic [5:0] {
        OP_RTYPE = 6'h00,
        OP_BEQ   = 6'h04,
        OP_ADDI  = 6'h08,
        OP_LW    = 6'h23,
        OP_SW    = 6'h2B
    } opcode_e;

    localparam int OP_HI  = 31;
    localparam int OP_LO  = 26;
    localparam int RS_HI  = 25;
    localparam int RS_LO  = 21;
    localparam int RT_HI  = 20;
    localparam int RT_LO  = 16;
    localparam int RD_HI  = 15;
    localparam int RD_LO  = 11;
    localparam int IMM_HI = 15;
    localparam int FN_HI  = 5;

    typedef struct packed {
        logic reg_write;
        logic mem_read;
        logic mem_write;
        logic branch;
        logic alu_src;
        logic illegal;
        logic uses_rs;
        logic uses_rt;
    } ctrl_t;

endpackage

// File: rtl/id_decoder.sv
// id_decoder: combinational MIPS decode of instr into control, destination and immediate.
module id_decoder
    import mips_pkg::*;
#(
    parameter int DATA_WIDTH  = 16,
    parameter int INSTR_WIDTH = 32
) (
    input  logic [INSTR_WIDTH-1:0] instr,
    output ctrl_t                  ctrl,
    output logic [4:0]             dest,
    output logic [DATA_WIDTH-1:0]  imm
);

    logic [5:0] op;

    assign op  = instr[OP_HI:OP_LO];
    assign imm = DATA_WIDTH'($signed(instr[IMM_HI:0]));

    always_comb begin
        ctrl = '0;
        dest = '0;
        case (op)
            OP_RTYPE: begin ctrl.uses_rs = 1'b1; ctrl.uses_rt = 1'b1; ctrl.reg_write = 1'b1; dest = instr[RD_HI:RD_LO]; end
            OP_ADDI:  begin ctrl.uses_rs = 1'b1; ctrl.alu_src = 1'b1; ctrl.reg_write = 1'b1; dest = instr[RT_HI:RT_LO]; end
            OP_LW:    begin ctrl.uses_rs = 1'b1; ctrl.alu_src = 1'b1; ctrl.mem_read = 1'b1; ctrl.reg_write = 1'b1; dest = instr[RT_HI:RT_LO]; end
            OP_SW:    begin ctrl.uses_rs = 1'b1; ctrl.uses_rt = 1'b1; ctrl.mem_write = 1'b1; ctrl.alu_src = 1'b1; end
            OP_BEQ:   begin ctrl.uses_rs = 1'b1; ctrl.uses_rt = 1'b1; ctrl.branch = 1'b1; end
            default:  ctrl.illegal = 1'b1;
        endcase
        if (dest == '0) ctrl.reg_write = 1'b0;
    end

endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: decode, load-use hazard detection and ID/EX register.
// Define ID_RF_BYPASS_EN to forward the writeback port onto ex_a/ex_b.
module id_ex_stage
    import mips_pkg::*;
#(
    parameter int RF_ADDRESS_WIDTH = 5,
    parameter int DATA_WIDTH       = 16,
    parameter int INSTR_WIDTH      = 32
) (
    input  logic                        clk,
    input  logic                        asyn_rst,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [INSTR_WIDTH-1:0]      instr,
    input  logic                        flush,
    input  logic                        ex_ready,
    output logic [RF_ADDRESS_WIDTH-1:0] rs1,
    output logic [RF_ADDRESS_WIDTH-1:0] rs2,
    input  logic [DATA_WIDTH-1:0]       Qs1,
    input  logic [DATA_WIDTH-1:0]       Qs2,
    input  logic                        wb_we,
    input  logic [RF_ADDRESS_WIDTH-1:0] wb_rd,
    input  logic [DATA_WIDTH-1:0]       wb_data,
    output logic                        ex_valid,
    output logic [5:0]                  ex_op,
    output logic [5:0]                  ex_funct,
    output logic [DATA_WIDTH-1:0]       ex_a,
    output logic [DATA_WIDTH-1:0]       ex_b,
    output logic [DATA_WIDTH-1:0]       ex_imm,
    output logic [RF_ADDRESS_WIDTH-1:0] ex_rd,
    output logic                        ex_reg_write,
    output logic                        ex_mem_read,
    output logic                        ex_mem_write,
    output logic                        ex_branch,
    output logic                        ex_alu_src,
    output logic                        ex_illegal
);

    ctrl_t                 ctrl;
    logic [4:0]            dest;
    logic [DATA_WIDTH-1:0] imm, a, b;
    logic [5:0]            ex_ctl;
    logic                  hazard, go;

    id_decoder #(.DATA_WIDTH(DATA_WIDTH), .INSTR_WIDTH(INSTR_WIDTH)) u_dec (
        .instr(instr),
        .ctrl (ctrl),
        .dest (dest),
        .imm  (imm)
    );

    assign rs1 = instr[RS_HI:RS_LO];
    assign rs2 = instr[RT_HI:RT_LO];

`ifdef ID_RF_BYPASS_EN
    assign a = (wb_we && wb_rd != '0 && wb_rd == rs1) ? wb_data : Qs1;
    assign b = (wb_we && wb_rd != '0 && wb_rd == rs2) ? wb_data : Qs2;
`else
    logic unused_wb;
    assign unused_wb = &{1'b0, wb_we, wb_rd, wb_data};
    assign a = Qs1;
    assign b = Qs2;
`endif

    assign hazard   = in_valid & ex_valid & ex_mem_read & (ex_rd != '0) &
                      ((ctrl.uses_rs & (ex_rd == rs1)) | (ctrl.uses_rt & (ex_rd == rs2)));
    assign in_ready = ~asyn_rst & (flush | (ex_ready & ~hazard));
    assign go       = in_valid & ~hazard;

    assign {ex_reg_write, ex_mem_read, ex_mem_write, ex_branch, ex_alu_src, ex_illegal} = ex_ctl;

    // Control is zeroed whenever ex_valid drops so EX never sees stale flags.
    always_ff @(posedge clk or posedge asyn_rst) begin
        if (asyn_rst) begin
            ex_valid <= 1'b0;
            ex_ctl   <= '0;
            ex_op    <= '0;
            ex_funct <= '0;
            ex_a     <= '0;
            ex_b     <= '0;
            ex_imm   <= '0;
            ex_rd    <= '0;
        end else if (flush) begin
            ex_valid <= 1'b0;
            ex_ctl   <= '0;
        end else if (ex_ready) begin
            ex_valid <= go;
            ex_ctl   <= go ? {ctrl.reg_write, ctrl.mem_read, ctrl.mem_write, ctrl.branch, ctrl.alu_src, ctrl.illegal} : '0;
            ex_op    <= instr[OP_HI:OP_LO];
            ex_funct <= instr[FN_HI:0];
            ex_a     <= a;
            ex_b     <= b;
            ex_imm   <= imm;
            ex_rd    <= dest;
        end
    end

endmodule
